// File: rtl/pc_fetch_ctrl.sv
// Fetch PC and single-outstanding instruction-fetch request controller.
// Applies sequential, branch/jump and trap redirects; kills in-flight responses on redirect.
module pc_fetch_ctrl #(
   parameter int unsigned XLEN       = 64,
   parameter logic [63:0] PC_INIT    = 64'h8000_0000,
   parameter int unsigned INST_BYTES = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   output logic            ireq_valid,
   output logic [XLEN-1:0] ireq_addr,
   input  logic            ireq_ready,
   input  logic            data_ok,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   output logic [XLEN-1:0] pc,
   output logic            inst_valid,
   output logic            misalign
);

   localparam int unsigned     OffW   = $clog2(INST_BYTES);
   localparam logic [XLEN-1:0] PcInit = PC_INIT[XLEN-1:0];
   localparam logic [XLEN-1:0] Step   = XLEN'(INST_BYTES);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic            pend_q, pend_d;

   logic            tgt_aligned;
   logic            redir;
   logic [XLEN-1:0] redir_tgt;
   logic [XLEN-1:0] pc_inc;

   // Trap targets bypass the alignment check; IDLE ignores every redirect.
   always_comb begin
      tgt_aligned = 1'b1;
      if (!trap_valid) begin
         tgt_aligned = (redirect_pc[OffW-1:0] == '0);
      end
      redir_tgt = trap_valid ? trap_pc : redirect_pc;
      redir     = (trap_valid | redirect_valid) & tgt_aligned & (state_q != StIdle);
      misalign  = redirect_valid & ~trap_valid & ~tgt_aligned & (state_q != StIdle);
      pc_inc    = pc_q + Step;
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      pend_pc_d  = pend_pc_q;
      ireq_valid = 1'b0;
      inst_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            state_d = StReq;
         end
         StReq: begin
            ireq_valid = 1'b1;
            if (ireq_ready) begin
               state_d = StWait;
               // Accepted request keeps its address; the redirect waits for the response.
               if (redir) begin
                  pend_d    = 1'b1;
                  pend_pc_d = redir_tgt;
               end
            end else if (redir) begin
               pc_d = redir_tgt;
            end
         end
         StWait: begin
            if (!data_ok) begin
               if (redir) begin
                  pend_d    = 1'b1;
                  pend_pc_d = redir_tgt;
               end
            end else if (pend_q || redir) begin
               pc_d    = redir ? redir_tgt : pend_pc_q;
               pend_d  = 1'b0;
               state_d = StReq;
            end else begin
               inst_valid = 1'b1;
               if (stall) begin
                  state_d = StHold;
               end else begin
                  pc_d    = pc_inc;
                  state_d = StReq;
               end
            end
         end
         StHold: begin
            inst_valid = 1'b1;
            if (redir) begin
               pc_d    = redir_tgt;
               state_d = StReq;
            end else if (!stall) begin
               pc_d    = pc_inc;
               state_d = StReq;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         pc_q      <= PcInit;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   assign pc        = pc_q;
   assign ireq_addr = pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: default reset vector instance plus a wrap-around instance.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   int unsigned total = 0;
   int unsigned bad   = 0;

   logic        reset_n, ireq_ready, data_ok, stall, redirect_valid, trap_valid;
   logic [63:0] redirect_pc, trap_pc;
   logic        ireq_valid, inst_valid, misalign;
   logic [63:0] ireq_addr, pc;

   logic        w_reset_n, w_ireq_ready, w_data_ok, w_stall, w_redirect_valid, w_trap_valid;
   logic [63:0] w_redirect_pc, w_trap_pc;
   logic        w_ireq_valid, w_inst_valid, w_misalign;
   logic [63:0] w_ireq_addr, w_pc;

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .ireq_ready     (ireq_ready),
      .data_ok        (data_ok),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .trap_valid     (trap_valid),
      .trap_pc        (trap_pc),
      .pc             (pc),
      .inst_valid     (inst_valid),
      .misalign       (misalign)
   );

   pc_fetch_ctrl #(
      .XLEN       (64),
      .PC_INIT    (64'hFFFF_FFFF_FFFF_FFFC),
      .INST_BYTES (4)
   ) dut_w (
      .clk            (clk),
      .reset_n        (w_reset_n),
      .ireq_valid     (w_ireq_valid),
      .ireq_addr      (w_ireq_addr),
      .ireq_ready     (w_ireq_ready),
      .data_ok        (w_data_ok),
      .stall          (w_stall),
      .redirect_valid (w_redirect_valid),
      .redirect_pc    (w_redirect_pc),
      .trap_valid     (w_trap_valid),
      .trap_pc        (w_trap_pc),
      .pc             (w_pc),
      .inst_valid     (w_inst_valid),
      .misalign       (w_misalign)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset_n = 1'b0; ireq_ready = 1'b0; data_ok = 1'b0; stall = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0102; trap_valid = 1'b0; trap_pc = '0;
      w_reset_n = 1'b0; w_ireq_ready = 1'b0; w_data_ok = 1'b0; w_stall = 1'b0;
      w_redirect_valid = 1'b0; w_redirect_pc = '0; w_trap_valid = 1'b0; w_trap_pc = '0;

      // Reset
      repeat (3) cyc();
      #1;
      chk("rst_pc", pc, 64'h8000_0000);
      chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
      chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
      chk("rst_misalign", {63'd0, misalign}, 64'd0);
      redirect_valid = 1'b0;
      reset_n = 1'b1;
      #1;
      chk("idle_ireq_valid", {63'd0, ireq_valid}, 64'd0);
      cyc(); #1;
      chk("first_req_valid", {63'd0, ireq_valid}, 64'd1);
      chk("first_req_addr", ireq_addr, 64'h8000_0000);

      // Sequential run
      ireq_ready = 1'b1;
      cyc(); ireq_ready = 1'b0; data_ok = 1'b1; #1;
      chk("seq0_inst_valid", {63'd0, inst_valid}, 64'd1);
      chk("seq0_pc", pc, 64'h8000_0000);
      chk("wait_no_req", {63'd0, ireq_valid}, 64'd0);
      cyc(); data_ok = 1'b0; ireq_ready = 1'b1; #1;
      chk("seq1_addr", ireq_addr, 64'h8000_0004);
      chk("req_no_inst", {63'd0, inst_valid}, 64'd0);

      // Stall for three cycles on the response of 8000_0004
      cyc(); ireq_ready = 1'b0; data_ok = 1'b1; stall = 1'b1; #1;
      chk("stall1_inst_valid", {63'd0, inst_valid}, 64'd1);
      chk("stall1_pc", pc, 64'h8000_0004);
      cyc(); data_ok = 1'b0; #1;
      chk("stall2_inst_valid", {63'd0, inst_valid}, 64'd1);
      chk("stall2_pc", pc, 64'h8000_0004);
      cyc(); #1;
      chk("stall3_inst_valid", {63'd0, inst_valid}, 64'd1);
      chk("stall3_pc", pc, 64'h8000_0004);
      cyc(); stall = 1'b0; #1;
      chk("release_inst_valid", {63'd0, inst_valid}, 64'd1);
      cyc(); #1;
      chk("seq2_valid", {63'd0, ireq_valid}, 64'd1);
      chk("seq2_addr", ireq_addr, 64'h8000_0008);

      // Redirect in WAIT two cycles before data_ok
      ireq_ready = 1'b1;
      cyc(); ireq_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0100; #1;
      chk("wait_redir_no_inst", {63'd0, inst_valid}, 64'd0);
      chk("wait_redir_pc_held", pc, 64'h8000_0008);
      cyc(); redirect_valid = 1'b0; #1;
      chk("wait_pend_pc_held", pc, 64'h8000_0008);
      cyc(); data_ok = 1'b1; #1;
      chk("killed_response", {63'd0, inst_valid}, 64'd0);
      cyc(); data_ok = 1'b0; #1;
      chk("redir_req_valid", {63'd0, ireq_valid}, 64'd1);
      chk("redir_req_addr", ireq_addr, 64'h8000_0100);

      // Trap and branch together in HOLD: trap wins
      ireq_ready = 1'b1;
      cyc(); ireq_ready = 1'b0; data_ok = 1'b1; stall = 1'b1; #1;
      chk("hold_entry_inst", {63'd0, inst_valid}, 64'd1);
      cyc(); data_ok = 1'b0;
      trap_valid = 1'b1; trap_pc = 64'h8000_0200;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0300; #1;
      chk("hold_inst_valid", {63'd0, inst_valid}, 64'd1);
      chk("trap_no_misalign", {63'd0, misalign}, 64'd0);
      cyc(); trap_valid = 1'b0; redirect_valid = 1'b0; stall = 1'b0; #1;
      chk("trap_priority_addr", ireq_addr, 64'h8000_0200);

      // Misaligned branch target in REQ
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0102; #1;
      chk("misalign_pulse", {63'd0, misalign}, 64'd1);
      cyc(); redirect_valid = 1'b0; #1;
      chk("misalign_pc_kept", ireq_addr, 64'h8000_0200);
      chk("misalign_cleared", {63'd0, misalign}, 64'd0);

      // Misaligned trap target is taken unchecked
      trap_valid = 1'b1; trap_pc = 64'h8000_0202; #1;
      chk("trap_misaligned_ok", {63'd0, misalign}, 64'd0);
      cyc(); trap_valid = 1'b0; #1;
      chk("trap_unaligned_addr", ireq_addr, 64'h8000_0202);

      // Redirect on the accept cycle: response killed, then target fetched
      ireq_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0400;
      cyc(); ireq_ready = 1'b0; redirect_valid = 1'b0; data_ok = 1'b1; #1;
      chk("accept_redir_killed", {63'd0, inst_valid}, 64'd0);
      cyc(); data_ok = 1'b0; #1;
      chk("accept_redir_addr", ireq_addr, 64'h8000_0400);

      // Wrap-around instance
      #1;
      chk("w_rst_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      w_reset_n = 1'b1;
      cyc(); #1;
      chk("w_first_addr", w_ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      w_ireq_ready = 1'b1;
      cyc(); w_ireq_ready = 1'b0; w_data_ok = 1'b1; #1;
      chk("w_inst_valid", {63'd0, w_inst_valid}, 64'd1);
      cyc(); w_data_ok = 1'b0; #1;
      chk("w_wrap_addr", w_ireq_addr, 64'd0);

      // Reset while in WAIT with a redirect pending
      w_ireq_ready = 1'b1;
      cyc(); w_ireq_ready = 1'b0; w_redirect_valid = 1'b1; w_redirect_pc = 64'h40;
      cyc(); w_redirect_valid = 1'b0; #1;
      w_reset_n = 1'b0; w_data_ok = 1'b1; #1;
      chk("w_async_rst_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("w_async_rst_inst", {63'd0, w_inst_valid}, 64'd0);
      chk("w_async_rst_req", {63'd0, w_ireq_valid}, 64'd0);
      cyc(); w_reset_n = 1'b1; #1;
      chk("w_stray_idle", {63'd0, w_inst_valid}, 64'd0);
      cyc(); #1;
      chk("w_stray_req", {63'd0, w_inst_valid}, 64'd0);
      chk("w_post_rst_addr", w_ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      w_data_ok = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Parametrised program-counter and fetch-request controller that supersedes the bare PC register in the single-cycle core. It holds the fetch PC and issues one outstanding instruction-fetch request at a time. It applies sequential increment, branch/jump redirect and trap redirect with fixed priority, and keeps an in-flight fetch alive across a redirect by killing its response rather than dropping it. It sits between the execute/CSR logic, which supplies redirects, and the instruction-memory port.

## Interface

Parameters:
- XLEN, 64, PC and address width.
- PC_INIT, 64'h8000_0000, reset vector. Only the low XLEN bits are used.
- INST_BYTES, 4, sequential increment. Must be a power of two, at least 2.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset. Assertion takes effect immediately, independent of clk.
- ireq_valid  out  1  fetch request valid.
- ireq_addr  out  XLEN  fetch address; always equals pc.
- ireq_ready  in  1  memory accepts the request this cycle.
- data_ok  in  1  instruction response for the outstanding request.
- stall  in  1  downstream cannot take the current instruction.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  XLEN  branch/jump target.
- trap_valid  in  1  exception/interrupt entry or mret.
- trap_pc  in  XLEN  trap/return target.
- pc  out  XLEN  PC of the current fetch.
- inst_valid  out  1  instruction at pc is valid for decode.
- misalign  out  1  one-cycle pulse: a redirect target was misaligned.

## Operation

States:
- IDLE: after reset.
- REQ: ireq_valid=1.
- WAIT: request accepted; awaiting data_ok.
- HOLD: instruction delivered but stalled.

Values during reset (reset_n low): pc=PC_INIT, state=IDLE, ireq_valid=0, inst_valid=0, misalign=0, pending flag cleared.

Redirect source and alignment:
- Effective redirect: trap_valid wins over redirect_valid. Target is trap_pc if trap_valid, else redirect_pc.
- Alignment rule: target[log2(INST_BYTES)-1:0] must be 0.
- Misaligned target: the redirect is ignored, misalign pulses for that cycle, and all other behaviour proceeds as if no redirect occurred.
- trap_pc is never checked for alignment.
- pc+INST_BYTES wraps modulo 2^XLEN.

Transitions (a "redirect" below means an effective, aligned redirect):
- IDLE → REQ unconditionally on the next edge.
- REQ, no redirect:
  - ireq_ready=1 → WAIT.
  - Otherwise stay in REQ with pc and ireq_addr held stable.
- REQ, redirect, ireq_ready=0: pc←target, stay in REQ. The address change is legal because the request was not yet accepted.
- REQ, redirect, ireq_ready=1: the request was accepted. pending←1, pend_pc←target, go to WAIT.
- WAIT, no data_ok:
  - redirect → pending←1, pend_pc←target. A later redirect overwrites pend_pc.
  - Stay in WAIT.
- WAIT, data_ok, and (pending or redirect this cycle): the response is killed (inst_valid=0).
  - pc←target if a redirect is present this cycle, else pc←pend_pc.
  - pending←0, go to REQ.
- WAIT, data_ok, not killed: inst_valid=1 in the same cycle.
  - stall=0 → pc←pc+INST_BYTES, go to REQ.
  - stall=1 → go to HOLD.
- HOLD: inst_valid=1 and pc is held.
  - redirect → pc←target, go to REQ. The redirect takes precedence over stall.
  - Else stall=0 → pc←pc+INST_BYTES, go to REQ.
  - Else stay in HOLD.

Other rules:
- data_ok outside WAIT is ignored. ireq_ready outside REQ is ignored.
- inst_valid is combinational: (WAIT & data_ok & ~kill) | HOLD.

## Timing

- Minimum sequential throughput is one instruction per 2 cycles (REQ→WAIT), plus memory latency.
- Reset release to the first ireq_valid: 1 cycle (the IDLE cycle).
- Redirect-to-request latency: the redirected address appears on ireq_addr the cycle after the redirect is applied.
- A redirect held pending in WAIT costs the remaining memory latency plus one cycle.
- Reset mid-operation:
  - All outputs return to their reset values immediately.
  - The pending redirect is discarded.
  - A late data_ok after reset release is ignored until the new WAIT state.

## Test plan

- Reset: hold reset_n=0, then release. Required: pc=PC_INIT (8000_0000) and ireq_valid=0 during reset. ireq_valid=1 with ireq_addr=8000_0000 on the 2nd cycle after release.
- Sequential run: ireq_ready=1, with data_ok one cycle after each accept. Required: ireq_addr sequence 8000_0000, 8000_0004, 8000_0008, with inst_valid once per address.
- Stall: assert stall for 3 cycles on the data_ok of 8000_0004. Required: inst_valid=1 and pc=8000_0004 held for 3 cycles, then the request for 8000_0008.
- Redirect in WAIT: in WAIT at 8000_0008, redirect_pc=8000_0100 two cycles before data_ok. Required: that response has inst_valid=0, and the next ireq_addr is 8000_0100.
- Simultaneous events: trap_valid (trap_pc=8000_0200) and redirect_valid (8000_0300) in the same HOLD cycle. Required: next ireq_addr=8000_0200.
  - Separately, redirect_pc=8000_0102 gives a misalign pulse and no change to pc.
- Wrap and reset: PC_INIT=FFFF_FFFF_FFFF_FFFC, one sequential step. Required: next ireq_addr=0.
  - Then assert reset_n low while in WAIT. Required: immediate return to PC_INIT; the stray data_ok after release produces no inst_valid.
